// File: rtl/mem_core_pipelined.sv
// Line-wide data memory with byte enables, in-order tagged read responses and a credit-checked
// response FIFO. Define MEM_CORE_INIT_EN to zero every line after reset before accepting requests.

`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif
`ifndef LINE_WIDTH
`define LINE_WIDTH 32
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 64
`endif

module mem_core_pipelined #(
    parameter int NUM_LINES  = `MEM_SIZE / (`LINE_WIDTH / `BYTE_WIDTH),
    parameter int LINE_WIDTH = `LINE_WIDTH,
    parameter int ADDR_WIDTH = $clog2(NUM_LINES),
    parameter int LATENCY    = 2,
    parameter int RESP_DEPTH = 4,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_write,
    input  logic [ADDR_WIDTH-1:0]             req_addr,
    input  logic [LINE_WIDTH-1:0]             req_data,
    input  logic [LINE_WIDTH/`BYTE_WIDTH-1:0] req_be,
    input  logic [TAG_WIDTH-1:0]              req_tag,
    output logic                              resp_valid,
    input  logic                              resp_ready,
    output logic [ADDR_WIDTH-1:0]             resp_addr,
    output logic [LINE_WIDTH-1:0]             resp_data,
    output logic [TAG_WIDTH-1:0]              resp_tag
);

    localparam int BYTE_W    = `BYTE_WIDTH;
    localparam int NUM_BYTES = LINE_WIDTH / BYTE_W;
    localparam int CNT_W     = $clog2(RESP_DEPTH + 1);
    localparam int PTR_W     = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    logic [LINE_WIDTH-1:0] mem_q [NUM_LINES];

    logic                  run;
    logic                  init_we;
    logic [ADDR_WIDTH-1:0] init_line;

    logic                  req_fire;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  resp_fire;
    logic                  push;

    logic [CNT_W-1:0]      outst_q, outst_d;
    logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
`ifdef MEM_CORE_INIT_EN
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_line_q, init_line_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_line_q <= '0;
        end else begin
            state_q     <= state_d;
            init_line_q <= init_line_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_line_d = init_line_q;
        case (state_q)
            ST_INIT: begin
                init_line_d = init_line_q + ADDR_WIDTH'(1);
                if (init_line_q == ADDR_WIDTH'(NUM_LINES - 1)) begin
                    state_d = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        run       = (state_q == ST_RUN);
        init_we   = (state_q == ST_INIT);
        init_line = init_line_q;
    end
`else
    state_e state;

    always_comb begin
        state     = ST_RUN;
        run       = (state == ST_RUN);
        init_we   = 1'b0;
        init_line = '0;
    end
`endif

    // ------------------------------------------------------------------
    // Request acceptance: writes also consume a credit check
    // ------------------------------------------------------------------
    always_comb begin
        req_ready = run && !reset && (outst_q < CNT_W'(RESP_DEPTH));
        req_fire  = req_valid && req_ready;
        wr_fire   = req_fire && req_write;
        rd_fire   = req_fire && !req_write;
        resp_fire = resp_valid && resp_ready;
    end

    always_ff @(posedge clock) begin
        if (init_we) begin
            mem_q[init_line] <= '0;
        end else if (wr_fire) begin
            for (int unsigned b = 0; b < NUM_BYTES; b++) begin
                if (req_be[b]) begin
                    mem_q[req_addr][b*BYTE_W +: BYTE_W] <= req_data[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. Stage 0 is the combinational array read in the accept
    // cycle, so LATENCY-1 register stages feed the FIFO push; element 0 of
    // the p*_q registers is unused and held at zero.
    // ------------------------------------------------------------------
    logic                  st_valid [LATENCY];
    logic [ADDR_WIDTH-1:0] st_addr  [LATENCY];
    logic [LINE_WIDTH-1:0] st_data  [LATENCY];
    logic [TAG_WIDTH-1:0]  st_tag   [LATENCY];

    logic                  pv_q [LATENCY];
    logic [ADDR_WIDTH-1:0] pa_q [LATENCY];
    logic [LINE_WIDTH-1:0] pd_q [LATENCY];
    logic [TAG_WIDTH-1:0]  pt_q [LATENCY];

    always_comb begin
        st_valid[0] = rd_fire;
        st_addr[0]  = req_addr;
        st_data[0]  = mem_q[req_addr];
        st_tag[0]   = req_tag;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            st_valid[i] = pv_q[i];
            st_addr[i]  = pa_q[i];
            st_data[i]  = pd_q[i];
            st_tag[i]   = pt_q[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pv_q[i] <= 1'b0;
            end
        end else begin
            pv_q[0] <= 1'b0;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pv_q[i] <= st_valid[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        pa_q[0] <= '0;
        pd_q[0] <= '0;
        pt_q[0] <= '0;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            pa_q[i] <= st_addr[i-1];
            pd_q[i] <= st_data[i-1];
            pt_q[i] <= st_tag[i-1];
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO and outstanding-read credit counter
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] fa_q [RESP_DEPTH];
    logic [LINE_WIDTH-1:0] fd_q [RESP_DEPTH];
    logic [TAG_WIDTH-1:0]  ft_q [RESP_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        push       = st_valid[LATENCY-1];
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = resp_fire ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        outst_d    = outst_q;
        case ({push, resp_fire})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: ;
        endcase
        case ({rd_fire, resp_fire})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            outst_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            outst_q    <= outst_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fa_q[wr_ptr_q] <= st_addr[LATENCY-1];
            fd_q[wr_ptr_q] <= st_data[LATENCY-1];
            ft_q[wr_ptr_q] <= st_tag[LATENCY-1];
        end
    end

    always_comb begin
        resp_valid = (fifo_cnt_q != '0);
        resp_addr  = fa_q[rd_ptr_q];
        resp_data  = fd_q[rd_ptr_q];
        resp_tag   = ft_q[rd_ptr_q];
    end

endmodule

// File: doc/mem_core_pipelined.md
# mem_core_pipelined

Parametrised, pipelined line-wide data memory for the core's memory stage. It accepts one read or write request per cycle over a valid/ready handshake and applies per-byte write enables. Reads return in order after a configurable latency, with the request tag echoed. An internal response FIFO with credit-based back-pressure buffers read data so the consumer can stall without losing data.

## Interface
- `NUM_LINES`, default `` `MEM_SIZE / (`LINE_WIDTH / `BYTE_WIDTH) ``: number of lines; power of two.
- `LINE_WIDTH`, default `` `LINE_WIDTH ``: bits per line; multiple of `` `BYTE_WIDTH ``.
- `ADDR_WIDTH`, default `$clog2(NUM_LINES)`: line-address width.
- `LATENCY`, default 2: read latency in cycles; range 1..8.
- `RESP_DEPTH`, default 4: response FIFO entries; must be ≥ `LATENCY`.
- `TAG_WIDTH`, default 4: request tag width.
- `clock`, in, 1: the single clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: request accepted this cycle when it is high together with `req_valid`.
- `req_write`, in, 1: 1 selects write, 0 selects read.
- `req_addr`, in, `ADDR_WIDTH`: line address.
- `req_data`, in, `LINE_WIDTH`: write data.
- `req_be`, in, `LINE_WIDTH/` `` `BYTE_WIDTH ``: byte enables; bit i covers byte i (LSB first).
- `req_tag`, in, `TAG_WIDTH`: echoed on the read response.
- `resp_valid`, out, 1: read response at the FIFO head.
- `resp_ready`, in, 1: consumer takes the response.
- `resp_addr`, out, `ADDR_WIDTH`: address of the returned read.
- `resp_data`, out, `LINE_WIDTH`: read data.
- `resp_tag`, out, `TAG_WIDTH`: tag of the returned read.

## Operation
- **Accept.** A request is accepted when `req_valid & req_ready`. At most one request per cycle.
- **Write.**
  - On acceptance, each byte with `req_be[i]=1` is updated; bytes with `req_be[i]=0` are untouched.
  - A write produces no response.
  - A write accepted in cycle N is visible to a read accepted in cycle N+1 or later.
- **Read.**
  - The array is sampled in the acceptance cycle.
  - The data passes through a `LATENCY`-stage valid/data/addr/tag pipeline and is pushed into the response FIFO.
  - `req_be` is ignored for reads.
- **Ordering.** Responses leave in acceptance order.
- **Outstanding counter.**
  - Width is `$clog2(RESP_DEPTH+1)`. It counts reads in the pipeline plus reads in the FIFO.
  - +1 on a read accept; −1 on `resp_valid & resp_ready`; unchanged when both happen in the same cycle.
- **`req_ready`.** Equals `state==RUN && outstanding < RESP_DEPTH`. It is high for writes as well; no write bypasses the credit check.
- **No overflow.** The pipeline never pushes into a full FIFO; the credit rule guarantees this.
- **`resp_*` outputs.** Driven from the FIFO head. `resp_valid` = FIFO not empty. The head stays stable while `resp_valid & !resp_ready`.
- **Reset.**
  - Clears pipeline valids, FIFO pointers and the counter. In-flight reads are dropped.
  - Array contents are retained unless `MEM_CORE_INIT_EN` is defined.
- **Addresses.** An address ≥ `NUM_LINES` is undefined; the bench must not drive it.

## Timing
- **Reset values.** `req_ready`=0, `resp_valid`=0. `resp_addr`, `resp_data` and `resp_tag` are don't-care while `resp_valid`=0.
- **Read latency.** A read accepted in cycle N, with FIFO empty, gives `resp_valid`=1 in cycle N+`LATENCY`.
- **Throughput.** With `resp_ready` held high, the block sustains one read per cycle indefinitely.
- **Back-pressure.** With `resp_ready` low, exactly `RESP_DEPTH` reads are accepted. `req_ready` falls in the cycle after the last accept.
- **Recovery from full.** A response handshake in cycle M while full raises `req_ready` in cycle M+1.
- **FIFO full and empty.**
  - A push and a pop in the same cycle are both legal, including on a full or empty FIFO.
  - A push into an empty FIFO becomes visible the next cycle; there is no same-cycle bypass.
- **Pointer wrap.** Pointers wrap modulo `RESP_DEPTH`; a non-power-of-two depth is supported.

## Configuration
- **`MEM_CORE_INIT_EN` defined.**
  - A two-state FSM is compiled in: INIT → RUN.
  - Reset enters INIT with the line counter at 0.
  - INIT writes all-zero to one line per cycle, lines 0..`NUM_LINES`−1, with `req_ready`=0.
  - After line `NUM_LINES`−1 is written, the FSM enters RUN, so `req_ready` rises `NUM_LINES` cycles after reset deasserts.
  - Reset asserted during INIT restarts from line 0.
- **`MEM_CORE_INIT_EN` undefined.**
  - The state is constant RUN.
  - `req_ready`=1 in the first cycle after reset deasserts.
  - Array contents are never cleared.

## Test plan
1. **Write then read.** Write 0xDEADBEEF to address 5 with all bytes enabled, then read address 5 tagged 3 in the next cycle. Expect `resp_data`=0xDEADBEEF, `resp_tag`=3, `resp_addr`=5, exactly `LATENCY` cycles after the read accept.
2. **Byte enables.** Write 0x11223344 to address 7, then 0xAABBCCDD with `req_be`=4'b0101, then read address 7. Expect 0x11BB33DD.
3. **Back-pressure.** With `resp_ready`=0, stream 6 reads to addresses 0..5 (`RESP_DEPTH`=4). Expect only 4 accepts and `req_ready`=0. Then raise `resp_ready`: expect responses for addresses 0..3 in order, then 4 and 5 accepted.
4. **Full throughput.** With `resp_ready`=1, issue 20 back-to-back reads. Expect `req_ready` constantly 1 and 20 ordered responses on consecutive cycles.
5. **Reset mid-flight.** Assert `reset` for one cycle while 3 reads are outstanding. Expect `resp_valid`=0 thereafter, no stale responses, and the counter back to 0 (`req_ready` restores per the configuration).
6. **Initialisation (`MEM_CORE_INIT_EN`).** Preload nonzero data, then reset. Expect `req_ready`=0 for `NUM_LINES` cycles, then a read of any address returns 0.
